// File: rtl/genis_getir_tamponu.sv
// Wide fetch buffer: takes a block of instructions per cycle, starting at the PC offset,
// and presents them one at a time at the head in first-word fall-through order.
module genis_getir_tamponu #(
  parameter int unsigned BUYRUK_SAYISI = 4,
  parameter int unsigned DERINLIK      = 8,
  parameter int unsigned PS_GENISLIK   = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          obek_gecerli_i,
  input  logic [32*BUYRUK_SAYISI-1:0]   obek_i,
  input  logic [PS_GENISLIK-1:0]        obek_ps_i,
  output logic                          obek_hazir_o,
  input  logic                          temizle_i,
  input  logic                          buyruk_hazir_i,
  output logic                          buyruk_gecerli_o,
  output logic [31:0]                   buyruk_o,
  output logic [PS_GENISLIK-1:0]        buyruk_ps_o,
  output logic [$clog2(DERINLIK):0]     sayac_o
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(BUYRUK_SAYISI);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]            buyruk_mem_q [DERINLIK];
  logic [PS_GENISLIK-1:0] ps_mem_q     [DERINLIK];

  logic [AW-1:0]          yaz_ptr_q, yaz_ptr_d;
  logic [AW-1:0]          oku_ptr_q, oku_ptr_d;
  logic [CW-1:0]          sayac_q, sayac_d;
  logic [PS_GENISLIK-1:0] son_ps_q;

  logic [OW-1:0]          ofs;
  logic [CW-1:0]          adet;
  logic                   kabul;
  logic                   oku;

  logic [BUYRUK_SAYISI-1:0] yaz_en;
  logic [AW-1:0]            yaz_adr [BUYRUK_SAYISI];
  logic [PS_GENISLIK-1:0]   yaz_ps  [BUYRUK_SAYISI];

  assign ofs              = obek_ps_i[OW+1:2];
  assign adet             = CW'(BUYRUK_SAYISI) - CW'(ofs);
  // Readiness only looks at the registered count, so a same-cycle read never helps.
  assign obek_hazir_o     = (CW'(DERINLIK) - sayac_q) >= CW'(BUYRUK_SAYISI);
  assign buyruk_gecerli_o = (sayac_q != '0);
  assign kabul            = obek_gecerli_i & obek_hazir_o & ~temizle_i;
  assign oku              = buyruk_hazir_i & buyruk_gecerli_o & ~temizle_i;

  // Instruction k lands at slot wp + (k - ofs) with PC obek_ps + 4*(k - ofs).
  always_comb begin
    for (int k = 0; k < BUYRUK_SAYISI; k++) begin
      yaz_en[k]  = kabul && (k >= int'(ofs));
      yaz_adr[k] = yaz_ptr_q + AW'(k) - AW'(ofs);
      yaz_ps[k]  = obek_ps_i + (PS_GENISLIK'(k) << 2) - PS_GENISLIK'({ofs, 2'b00});
    end
  end

  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayac_d   = sayac_q;
    if (temizle_i) begin
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
      sayac_d   = '0;
    end else begin
      if (kabul) yaz_ptr_d = yaz_ptr_q + AW'(adet);
      if (oku)   oku_ptr_d = oku_ptr_q + AW'(1);
      sayac_d = sayac_q + (kabul ? adet : CW'(0)) - (oku ? CW'(1) : CW'(0));
    end
  end

  assign buyruk_o    = buyruk_gecerli_o ? buyruk_mem_q[oku_ptr_q] : Nop;
  assign buyruk_ps_o = buyruk_gecerli_o ? ps_mem_q[oku_ptr_q] : son_ps_q;
  assign sayac_o     = sayac_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
      son_ps_q  <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayac_q   <= sayac_d;
      son_ps_q  <= buyruk_ps_o;
    end
  end

  // Storage has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BUYRUK_SAYISI; k++) begin
      if (rst_i && yaz_en[k]) begin
        buyruk_mem_q[yaz_adr[k]] <= obek_i[32*k +: 32];
        ps_mem_q[yaz_adr[k]]     <= yaz_ps[k];
      end
    end
  end

endmodule

// File: tb/tb_genis_getir_tamponu.sv
// Scoreboard bench for genis_getir_tamponu: writes push expected entries, a monitor
// pops and compares on every consumed head instruction.
module tb_genis_getir_tamponu;

  localparam int unsigned B  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = 32;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            obek_gecerli_i = 1'b0;
  logic [32*B-1:0] obek_i = '0;
  logic [PW-1:0]   obek_ps_i = '0;
  logic            obek_hazir_o;
  logic            temizle_i = 1'b0;
  logic            buyruk_hazir_i = 1'b0;
  logic            buyruk_gecerli_o;
  logic [31:0]     buyruk_o;
  logic [PW-1:0]   buyruk_ps_o;
  logic [3:0]      sayac_o;

  genis_getir_tamponu #(
    .BUYRUK_SAYISI(B),
    .DERINLIK     (D),
    .PS_GENISLIK  (PW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .obek_gecerli_i  (obek_gecerli_i),
    .obek_i          (obek_i),
    .obek_ps_i       (obek_ps_i),
    .obek_hazir_o    (obek_hazir_o),
    .temizle_i       (temizle_i),
    .buyruk_hazir_i  (buyruk_hazir_i),
    .buyruk_gecerli_o(buyruk_gecerli_o),
    .buyruk_o        (buyruk_o),
    .buyruk_ps_o     (buyruk_ps_o),
    .sayac_o         (sayac_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] ps;
  } beklenen_t;

  beklenen_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block words are taban+k; expected entries follow from the PC offset.
  task automatic yaz(input logic [31:0] ps, input logic [31:0] taban, input bit kabul_bekle);
    int o;
    o = int'(ps[3:2]);
    obek_gecerli_i = 1'b1;
    obek_ps_i      = ps;
    for (int k = 0; k < B; k++) obek_i[32*k +: 32] = taban + 32'(k);
    if (kabul_bekle) begin
      for (int k = o; k < B; k++) q.push_back('{b: taban + 32'(k), ps: ps + 32'(4 * (k - o))});
    end
    tick();
    obek_gecerli_i = 1'b0;
  endtask

  task automatic bosalt(input int n);
    buyruk_hazir_i = 1'b1;
    repeat (n) tick();
    buyruk_hazir_i = 1'b0;
  endtask

  // Monitor: a head consumption happens at the coming edge.
  initial begin
    beklenen_t e;
    forever begin
      @(negedge clk);
      if (rst_i && !temizle_i && buyruk_hazir_i && buyruk_gecerli_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %h expected no entry", buyruk_o);
        end else begin
          e = q.pop_front();
          kontrol("head_instr", buyruk_o, e.b);
          kontrol("head_ps", buyruk_ps_o, e.ps);
        end
      end
    end
  end

  initial begin
    // Reset
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    kontrol("rst_sayac", 32'(sayac_o), 32'd0);
    kontrol("rst_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("rst_buyruk", buyruk_o, 32'h13);
    kontrol("rst_ps", buyruk_ps_o, 32'h0);
    kontrol("rst_hazir", 32'(obek_hazir_o), 32'd1);

    // Basic write and drain
    yaz(32'h1000, 32'hA0, 1'b1);
    kontrol("bas_sayac", 32'(sayac_o), 32'd4);
    kontrol("bas_buyruk", buyruk_o, 32'hA0);
    kontrol("bas_ps", buyruk_ps_o, 32'h1000);
    bosalt(4);
    kontrol("bos_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("bos_buyruk", buyruk_o, 32'h13);
    kontrol("bos_ps_tut", buyruk_ps_o, 32'h100C);

    // Read while empty
    bosalt(2);
    kontrol("bos_oku_sayac", 32'(sayac_o), 32'd0);

    // Offset write
    yaz(32'h2008, 32'hB0, 1'b1);
    kontrol("ofs_sayac", 32'(sayac_o), 32'd2);
    kontrol("ofs_buyruk", buyruk_o, 32'hB2);
    bosalt(2);

    // Full buffer, third block dropped
    yaz(32'h4000, 32'hC0, 1'b1);
    yaz(32'h4010, 32'hD0, 1'b1);
    kontrol("dolu_sayac", 32'(sayac_o), 32'd8);
    kontrol("dolu_hazir", 32'(obek_hazir_o), 32'd0);
    yaz(32'h4020, 32'hE0, 1'b0);
    kontrol("dusur_sayac", 32'(sayac_o), 32'd8);
    bosalt(8);
    kontrol("dolu_q_bos", 32'(q.size()), 32'd0);
    kontrol("dolu_son_sayac", 32'(sayac_o), 32'd0);

    // Wrap with same-cycle read and write: wp=6, rp=4
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    q.delete();
    yaz(32'h5000, 32'h50, 1'b1);
    bosalt(4);
    yaz(32'h5008, 32'h60, 1'b1);
    buyruk_hazir_i = 1'b1;
    yaz(32'h5100, 32'h70, 1'b1);
    buyruk_hazir_i = 1'b0;
    kontrol("sar_sayac", 32'(sayac_o), 32'd5);
    bosalt(5);
    kontrol("sar_q_bos", 32'(q.size()), 32'd0);

    // Flush with same-cycle write
    yaz(32'h6000, 32'h80, 1'b1);
    yaz(32'h600C, 32'h90, 1'b1);
    kontrol("tem_once_sayac", 32'(sayac_o), 32'd5);
    temizle_i = 1'b1;
    buyruk_hazir_i = 1'b1;
    yaz(32'h7000, 32'hF0, 1'b0);
    temizle_i = 1'b0;
    buyruk_hazir_i = 1'b0;
    q.delete();
    kontrol("tem_sayac", 32'(sayac_o), 32'd0);
    kontrol("tem_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    yaz(32'h3000, 32'h30, 1'b1);
    kontrol("tem_sonra_ps", buyruk_ps_o, 32'h3000);
    kontrol("tem_sonra_buyruk", buyruk_o, 32'h30);
    bosalt(4);

    // Reset mid-operation with a write request
    yaz(32'h8000, 32'h40, 1'b1);
    yaz(32'h800C, 32'h48, 1'b1);
    kontrol("rst2_once_sayac", 32'(sayac_o), 32'd5);
    rst_i = 1'b0;
    yaz(32'h9000, 32'h20, 1'b0);
    rst_i = 1'b1;
    q.delete();
    kontrol("rst2_sayac", 32'(sayac_o), 32'd0);
    kontrol("rst2_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("rst2_buyruk", buyruk_o, 32'h13);
    kontrol("rst2_hazir", 32'(obek_hazir_o), 32'd1);
    kontrol("rst2_ps", buyruk_ps_o, 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/genis_getir_tamponu.md
GENIS_GETIR_TAMPONU -- requirements
Module: genis_getir_tamponu

Interface
REQ-001 Parameter BUYRUK_SAYISI, default 4: number of 32-bit instructions per fetched block; power of two, at least 2.
REQ-002 Parameter DERINLIK, default 8: number of instruction entries; power of two, at least 2*BUYRUK_SAYISI.
REQ-003 Parameter PS_GENISLIK, default 32: program counter width.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-low.
REQ-006 obek_gecerli_i  input  1  block write request.
REQ-007 obek_i  input  32*BUYRUK_SAYISI  instruction block; instruction k is bits [32k+31:32k].
REQ-008 obek_ps_i  input  PS_GENISLIK  PC of the first wanted instruction; bits [1:0] are zero.
REQ-009 obek_hazir_o  output  1  buffer can accept a full block this cycle.
REQ-010 temizle_i  input  1  flush, for redirect or misprediction.
REQ-011 buyruk_hazir_i  input  1  consumer takes the head instruction.
REQ-012 buyruk_gecerli_o  output  1  head entry is valid.
REQ-013 buyruk_o  output  32  head instruction.
REQ-014 buyruk_ps_o  output  PS_GENISLIK  PC of the head instruction.
REQ-015 sayac_o  output  log2(DERINLIK)+1  current occupancy.

Function
REQ-016 Offset: o = obek_ps_i[log2(BUYRUK_SAYISI)+1:2]; an accepted block writes instructions o..BUYRUK_SAYISI-1 only, giving n = BUYRUK_SAYISI-o entries.
REQ-017 Entry PCs: the entry holding instruction k gets obek_ps_i + 4*(k-o), computed modulo 2^PS_GENISLIK.
REQ-018 Order: entries are written to consecutive slots from the write pointer, in increasing k.
REQ-019 obek_hazir_o = 1 when (DERINLIK - sayac_o) >= BUYRUK_SAYISI; it uses the registered count and ignores any same-cycle read.
REQ-020 Write acceptance: a block is accepted only when obek_gecerli_i=1, obek_hazir_o=1 and temizle_i=0. Otherwise it is dropped with no state change, and no partial write occurs.
REQ-021 Head output: the head entry is presented combinationally (first-word fall-through). A written entry becomes visible at the head one cycle after the accepting edge.
REQ-022 buyruk_gecerli_o = (sayac_o != 0).
REQ-023 When empty: buyruk_o = 32'h0000_0013 (NOP) and buyruk_ps_o holds its last value.
REQ-024 Read: the head is consumed when buyruk_hazir_i=1, buyruk_gecerli_o=1 and temizle_i=0. The read pointer advances by 1.
REQ-025 Read when empty: buyruk_hazir_i=1 with the buffer empty has no effect.
REQ-026 Same-cycle read and write: an accepted write and a read in the same cycle both occur. Next sayac_o = sayac_o + n - 1.
REQ-027 Pointer wrap: read and write pointers wrap modulo DERINLIK. A block that straddles the end of storage wraps its entries into slot 0 onward.
REQ-028 Flush: temizle_i=1 sets both pointers and sayac_o to 0 at the next edge. It discards any same-cycle write and read; buyruk_gecerli_o=0 in the following cycle.
REQ-029 Count bound: sayac_o never exceeds DERINLIK, guaranteed by REQ-019.
REQ-030 Count decrement: sayac_o changes only through REQ-020, REQ-024, REQ-026 and REQ-028.

Reset
REQ-031 Reset values, applied when rst_i=0 at a rising edge: pointers 0, sayac_o 0, buyruk_gecerli_o 0, buyruk_o 32'h0000_0013, buyruk_ps_o 0, obek_hazir_o 1.
REQ-032 Reset priority: reset overrides temizle_i and all writes and reads in the same cycle.
REQ-033 Storage contents are not reset.

Verification (BUYRUK_SAYISI=4, DERINLIK=8)
REQ-034 Basic write and drain:
- Stimulus: after reset, write block {A3,A2,A1,A0} at ps 0x1000, then buyruk_hazir_i=1.
- Response: next cycle buyruk_o=A0, ps=0x1000, sayac=4. The following cycles give A1..A3 at 0x1004..0x100C, then gecerli=0 and buyruk_o=0x13.
REQ-035 Offset write:
- Stimulus: write block at ps 0x2008.
- Response: sayac=2; entries A2 at 0x2008 and A3 at 0x200C.
REQ-036 Full buffer:
- Stimulus: buyruk_hazir_i=0; write two full blocks, then a third block with obek_gecerli_i=1.
- Response: sayac=8 and obek_hazir_o=0 after the second block; the third block is dropped and sayac stays 8.
REQ-037 Flush with same-cycle write:
- Stimulus: sayac=5, then temizle_i=1 together with obek_gecerli_i=1.
- Response: next cycle sayac=0 and gecerli=0; the next accepted block at ps 0x3000 appears with head ps 0x3000.
REQ-038 Wrap with same-cycle read and write:
- Stimulus: write pointer at 6, read pointer at 4 (sayac=2); write a full block with buyruk_hazir_i=1.
- Response: sayac=5; entries land in slots 6,7,0,1; read order is preserved across the wrap.
REQ-039 Reset mid-operation:
- Stimulus: sayac=5, then rst_i=0 for one edge with obek_gecerli_i=1.
- Response: sayac=0, gecerli=0, buyruk_o=0x13, obek_hazir_o=1.
